// File: rtl/puf_majority_voter_if.sv
// Signal bundle between the majority voter, its requester (UART side) and the ring-oscillator PUF.
// The slave modport is the voter's view; master is the surrounding environment.
interface puf_majority_voter_if #(
  parameter int unsigned CHAL_W = 8,
  parameter int unsigned RESP_W = 256
);
  localparam int unsigned POP_W = $clog2(RESP_W + 1);

  logic              start;
  logic [CHAL_W-1:0] challenge;
  logic              busy;
  logic              puf_start;
  logic [CHAL_W-1:0] puf_challenge;
  logic [RESP_W-1:0] puf_response;
  logic              puf_done;
  logic [RESP_W-1:0] response;
  logic [RESP_W-1:0] unstable_mask;
  logic [POP_W-1:0]  unstable_count;
  logic              error;
  logic              done;

  modport master (
    output start, challenge, puf_response, puf_done,
    input  busy, puf_start, puf_challenge, response, unstable_mask, unstable_count, error, done
  );

  modport slave (
    input  start, challenge, puf_response, puf_done,
    output busy, puf_start, puf_challenge, response, unstable_mask, unstable_count, error, done
  );
endinterface

// File: rtl/puf_majority_voter.sv
// Runs NUM_EVAL PUF evaluations per challenge, keeps per-bit vote counts and returns the
// majority response, a mask of non-unanimous bits and its popcount. A watchdog flags a stalled PUF.
module puf_majority_voter #(
  parameter int unsigned CHAL_W   = 8,
  parameter int unsigned RESP_W   = 256,
  parameter int unsigned NUM_EVAL = 5,
  parameter int unsigned TIMEOUT  = 65535
) (
  input logic                clk,
  input logic                reset,
  puf_majority_voter_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(NUM_EVAL + 1);
  localparam int unsigned POP_W = $clog2(RESP_W + 1);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StFinish} state_e;

  state_e            state_q, state_d;
  logic [CHAL_W-1:0] chal_q, chal_d;
  logic [CNT_W-1:0]  eval_idx_q, eval_idx_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q [RESP_W];
  logic [CNT_W-1:0]  cnt_d [RESP_W];
  logic [RESP_W-1:0] response_q, response_d;
  logic [RESP_W-1:0] mask_q, mask_d;
  logic [POP_W-1:0]  count_q, count_d;
  logic              error_q, error_d;
  logic              done_q, done_d;
  logic              puf_start_q, puf_start_d;

  logic [CNT_W-1:0]  nsamp;
  logic [RESP_W-1:0] vote_resp, vote_mask;
  logic [POP_W-1:0]  vote_pop;
  logic              wd_expired;

  // Leaving WAIT after TIMEOUT-1 idle cycles puts done at launch + TIMEOUT + 1.
  assign wd_expired = (32'(wd_q) + 32'd1) >= (TIMEOUT - 32'd1);

  // After a timeout only eval_idx samples were taken; votes are judged against that count.
  always_comb begin
    nsamp     = error_q ? eval_idx_q : CNT_W'(NUM_EVAL);
    vote_resp = '0;
    vote_mask = '0;
    vote_pop  = '0;
    for (int i = 0; i < RESP_W; i++) begin
      vote_resp[i] = {cnt_q[i], 1'b0} > {1'b0, nsamp};
      vote_mask[i] = (cnt_q[i] != '0) && (cnt_q[i] != nsamp);
      vote_pop     = vote_pop + POP_W'(vote_mask[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    chal_d      = chal_q;
    eval_idx_d  = eval_idx_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    response_d  = response_q;
    mask_d      = mask_q;
    count_d     = count_q;
    error_d     = error_q;
    done_d      = 1'b0;
    puf_start_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          chal_d      = bus.challenge;
          eval_idx_d  = '0;
          error_d     = 1'b0;
          puf_start_d = 1'b1;
          state_d     = StLaunch;
          for (int i = 0; i < RESP_W; i++) cnt_d[i] = '0;
        end
      end
      StLaunch: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.puf_done) begin
          for (int i = 0; i < RESP_W; i++) cnt_d[i] = cnt_q[i] + CNT_W'(bus.puf_response[i]);
          if (eval_idx_q == CNT_W'(NUM_EVAL - 1)) begin
            state_d = StFinish;
          end else begin
            eval_idx_d  = eval_idx_q + CNT_W'(1);
            puf_start_d = 1'b1;
            state_d     = StLaunch;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = StFinish;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      StFinish: begin
        response_d = vote_resp;
        mask_d     = vote_mask;
        count_d    = vote_pop;
        done_d     = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      chal_q      <= '0;
      eval_idx_q  <= '0;
      wd_q        <= '0;
      response_q  <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      puf_start_q <= 1'b0;
      for (int i = 0; i < RESP_W; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      chal_q      <= chal_d;
      eval_idx_q  <= eval_idx_d;
      wd_q        <= wd_d;
      response_q  <= response_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      error_q     <= error_d;
      done_q      <= done_d;
      puf_start_q <= puf_start_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.busy           = (state_q != StIdle);
  assign bus.puf_start      = puf_start_q;
  assign bus.puf_challenge  = chal_q;
  assign bus.response       = response_q;
  assign bus.unstable_mask  = mask_q;
  assign bus.unstable_count = count_q;
  assign bus.error          = error_q;
  assign bus.done           = done_q;
endmodule
